reg_bank: RTL and testbench
===========================

// Module: reg_bank
// PURPOSE
//   32x32 MIPS general-purpose register file: the consumer of the write-register selector's output.
//   One synchronous write port and two read ports feeding registered A/B operand latches.
//   The latches are loaded in the multicycle decode step.
//   Writes to $zero are discarded; $sp is preset at reset.
//   A combinational debug read port exposes any register to the bench.
// PARAMETERS
//   SP_INIT   32'h0000_00E3  reset value of register 29 ($sp)
//   NREGS     32             register count (fixed by ISA; index width 5)
// PORTS
//   clk          in   1   single clock, all state updates on rising edge
//   reset_n      in   1   asynchronous, active-low reset
//   reg_write    in   1   write enable for this cycle
//   write_reg    in   32  destination index from write-register selector; only [4:0] used, [31:5] ignored
//   write_data   in   32  data to write
//   read_reg_1   in   5   source index for operand A
//   read_reg_2   in   5   source index for operand B
//   load_ab      in   1   capture operands into A/B latches this cycle
//   read_data_a  out  32  registered operand A
//   read_data_b  out  32  registered operand B
//   dbg_reg      in   5   debug read index
//   dbg_data     out  32  combinational value of register dbg_reg
//   wr_count     out  16  number of committed (non-$zero) writes since reset, wraps
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous, any time incl. mid-instruction):
//     - all registers = 0, except r29 = SP_INIT.
//     - read_data_a = read_data_b = 0; wr_count = 0.
//     - Released state is valid on the first rising edge after reset_n=1.
//   Write:
//     - On a rising edge with reg_write=1 and wa=write_reg[4:0] != 0: r[wa] <= write_data.
//     - The write also increments wr_count (16-bit, FFFF -> 0000).
//     - reg_write=1 with wa=0: no state change, wr_count unchanged.
//     - reg_write=0: write_reg and write_data are don't-care.
//   Operand latches:
//     - On a rising edge with load_ab=1: read_data_a <= f(read_reg_1) and read_data_b <= f(read_reg_2).
//     - load_ab=0: latches hold.
//     - f(i)=0 if i=0.
//     - Else f(i)=write_data if reg_write=1 and wa==i, which is write-through bypass in the same edge.
//     - Else f(i)=r[i].
//     - Latency: operand visible 1 cycle after the load_ab edge; written value readable via a latch 1 cycle later,
//       or in the same edge via bypass.
//     - read_reg_1 == read_reg_2: both latches get the same value.
//   Debug port:
//     - dbg_data = r[dbg_reg]; dbg_reg=0 gives 0.
//     - Shows the pre-edge value; no bypass.
//   Simultaneous events:
//     - Write + load_ab to different indices are independent.
//     - Asynchronous reset overrides both.
// TESTING
//   1 Reset: reset_n=0 mid-write of r5=32'h1234 -> after release r5=0, r29=SP_INIT, read_data_a/b=0, wr_count=0.
//   2 Write/read: write r8=32'hDEADBEEF; next cycle load_ab with read_reg_1=8 -> read_data_a=32'hDEADBEEF,
//     wr_count=1.
//   3 $zero: reg_write=1, write_reg=32'h0, write_data=32'hFFFF_FFFF; load_ab read_reg_2=0 -> read_data_b=0,
//     wr_count unchanged.
//   4 Bypass: same edge reg_write=1 write_reg=31 write_data=32'h0040_0010, load_ab, read_reg_1=read_reg_2=31
//     -> both latches 32'h0040_0010.
//   5 Upper bits ignored: write_reg=32'h0000_003D with write_data=7 -> r29=7 (index 29), dbg_data@29=7.
//   6 Counter wrap: 65536 writes to r1 -> wr_count=0; load_ab=0 cycles -> latches hold prior values.

Source files
------------

// File: rtl/reg_bank.sv
// 32x32 MIPS general-purpose register file.
// It has one synchronous write port and two read ports that load registered A/B operand latches.
// A write to $zero is dropped, and $sp gets a preset value at reset.
// A combinational debug read port can show any register.
module reg_bank #(
  parameter logic [31:0] SP_INIT = 32'h0000_00E3,
  parameter int unsigned NREGS   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_write,
  input  logic [31:0] write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg_1,
  input  logic [4:0]  read_reg_2,
  input  logic        load_ab,
  output logic [31:0] read_data_a,
  output logic [31:0] read_data_b,
  input  logic [4:0]  dbg_reg,
  output logic [31:0] dbg_data,
  output logic [15:0] wr_count
);

  localparam int unsigned SpIdx = 29;

  logic [31:0] regs_q [NREGS];
  logic [31:0] a_q, b_q;
  logic [15:0] cnt_q;

  logic [4:0]  wa;
  logic        wr_en;
  logic [31:0] a_d, b_d;

  // The write-register selector sends a full word, and only the low five bits select a register.
  assign wa = write_reg[4:0];

  logic unused_write_reg_hi;
  assign unused_write_reg_hi = ^write_reg[31:5];

  // Only a write to a non-zero index is committed and counted.
  assign wr_en = reg_write && (wa != 5'd0);

  // Operand select: $zero reads as zero, and a same-edge write to that index is bypassed.
  always_comb begin
    a_d = 32'h0;
    b_d = 32'h0;
    if (read_reg_1 != 5'd0) begin
      a_d = (wr_en && (wa == read_reg_1)) ? write_data : regs_q[read_reg_1];
    end
    if (read_reg_2 != 5'd0) begin
      b_d = (wr_en && (wa == read_reg_2)) ? write_data : regs_q[read_reg_2];
    end
  end

  // Register array storage. $sp gets its preset value and every other register clears to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SpIdx) ? SP_INIT : 32'h0;
      end
    end else if (wr_en) begin
      regs_q[wa] <= write_data;
    end
  end

  // A/B operand latches, loaded in the decode step and held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= 32'h0;
      b_q <= 32'h0;
    end else if (load_ab) begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Committed-write counter. It wraps at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'h0;
    end else if (wr_en) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // The debug read has no bypass, so it shows the value from before the edge.
  always_comb begin
    dbg_data = 32'h0;
    if (dbg_reg != 5'd0) begin
      dbg_data = regs_q[dbg_reg];
    end
  end

  assign read_data_a = a_q;
  assign read_data_b = b_q;
  assign wr_count    = cnt_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank. It runs a table of vectors through a scoreboard queue
// and then hand-written sequences for the async reset, the pre-edge debug read and the counter wrap.
module tb_reg_bank;

  localparam logic [31:0] SpInit = 32'h0000_00E3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_write;
  logic [31:0] write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic        load_ab;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;
  logic [4:0]  dbg_reg;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_bank #(.SP_INIT(SpInit), .NREGS(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg_1 (read_reg_1),
    .read_reg_2 (read_reg_2),
    .load_ab    (load_ab),
    .read_data_a(read_data_a),
    .read_data_b(read_data_b),
    .dbg_reg    (dbg_reg),
    .dbg_data   (dbg_data),
    .wr_count   (wr_count)
  );

  typedef struct {
    logic        rw;
    logic [31:0] wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ld;
    logic [4:0]  dbg;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ed;
    logic [15:0] ec;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ed;
    logic [15:0] ec;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle();
    reg_write  = 1'b0;
    write_reg  = 32'h0;
    write_data = 32'h0;
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd0;
    load_ab    = 1'b0;
  endtask

  // Drive one vector on the falling edge, queue what it should produce, then check after the rising edge.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    reg_write  = v.rw;
    write_reg  = v.wr;
    write_data = v.wd;
    read_reg_1 = v.r1;
    read_reg_2 = v.r2;
    load_ab    = v.ld;
    dbg_reg    = v.dbg;
    sb.push_back('{idx, v.ea, v.eb, v.ed, v.ec});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk($sformatf("vec%0d_a", e.idx), read_data_a, e.ea);
      chk($sformatf("vec%0d_b", e.idx), read_data_b, e.eb);
      chk($sformatf("vec%0d_dbg", e.idx), dbg_data, e.ed);
      chk($sformatf("vec%0d_cnt", e.idx), {16'h0, wr_count}, {16'h0, e.ec});
    end
  endtask

  initial begin
    // This table starts from the reset state: r29=SP_INIT, counter 0, latches 0.
    //           rw    wr            wd            r1     r2     ld    dbg    ea            eb            ed            ec
    vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 5'd0,  5'd0,  1'b0, 5'd8,  32'h0,        32'h0,        32'hDEAD_BEEF, 16'd1};
    vecs[1] = '{1'b0, 32'h0,        32'h0,        5'd8,  5'd29, 1'b1, 5'd8,  32'hDEAD_BEEF, SpInit,       32'hDEAD_BEEF, 16'd1};
    vecs[2] = '{1'b1, 32'h0,        32'hFFFF_FFFF, 5'd8,  5'd0,  1'b1, 5'd0,  32'hDEAD_BEEF, 32'h0,        32'h0,        16'd1};
    vecs[3] = '{1'b1, 32'h0000_001F, 32'h0040_0010, 5'd31, 5'd31, 1'b1, 5'd31, 32'h0040_0010, 32'h0040_0010, 32'h0040_0010, 16'd2};
    vecs[4] = '{1'b1, 32'h0000_003D, 32'h0000_0007, 5'd0,  5'd0,  1'b0, 5'd29, 32'h0040_0010, 32'h0040_0010, 32'h7,        16'd3};
    vecs[5] = '{1'b0, 32'h0,        32'h0,        5'd29, 5'd5,  1'b1, 5'd29, 32'h7,        32'h0,        32'h7,        16'd3};
    vecs[6] = '{1'b1, 32'hFFFF_FFE1, 32'h0000_0011, 5'd1,  5'd8,  1'b1, 5'd1,  32'h11,       32'hDEAD_BEEF, 32'h11,       16'd4};
    vecs[7] = '{1'b0, 32'h0000_0002, 32'h0000_0099, 5'd2,  5'd1,  1'b1, 5'd2,  32'h0,        32'h11,       32'h0,        16'd4};
    vecs[8] = '{1'b1, 32'h0000_0002, 32'h0000_0022, 5'd8,  5'd31, 1'b1, 5'd2,  32'hDEAD_BEEF, 32'h0040_0010, 32'h22,       16'd5};

    idle();
    dbg_reg = 5'd0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dbg_reg = 5'd29;
    #1;
    chk("reset_sp", dbg_data, SpInit);
    chk("reset_a", read_data_a, 32'h0);
    chk("reset_cnt", {16'h0, wr_count}, 32'h0);

    // Build up some state, then assert reset during a write to r5.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 32'd5; write_data = 32'h0000_AAAA;
    load_ab = 1'b1; read_reg_1 = 5'd5; read_reg_2 = 5'd29;
    @(posedge clk);
    #1;
    chk("pre_a_bypass", read_data_a, 32'h0000_AAAA);
    chk("pre_b", read_data_b, SpInit);
    chk("pre_cnt", {16'h0, wr_count}, 32'd1);
    @(negedge clk);
    load_ab = 1'b0; write_data = 32'h0000_1234;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_a", read_data_a, 32'h0);
    chk("async_b", read_data_b, 32'h0);
    chk("async_cnt", {16'h0, wr_count}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    dbg_reg = 5'd5;
    #1;
    chk("rst_r5", dbg_data, 32'h0);
    dbg_reg = 5'd29;
    #1;
    chk("rst_sp", dbg_data, SpInit);
    chk("rst_b", read_data_b, 32'h0);
    chk("rst_cnt", {16'h0, wr_count}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      apply(i, vecs[i]);
    end

    // The debug port shows the value from before the edge, so a pending write is not visible yet.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 32'd3; write_data = 32'h0000_0055;
    load_ab = 1'b0; dbg_reg = 5'd3;
    #1;
    chk("dbg_pre_edge", dbg_data, 32'h0);
    @(posedge clk);
    #1;
    chk("dbg_post_edge", dbg_data, 32'h0000_0055);
    chk("cnt_after_r3", {16'h0, wr_count}, 32'd6);

    // Counter wrap: start from reset and do 65536 writes to r1. The latches are loaded only on the first write.
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    reg_write = 1'b1; write_reg = 32'd1; write_data = 32'h0;
    load_ab = 1'b1; read_reg_1 = 5'd29; read_reg_2 = 5'd0;
    @(negedge clk);
    load_ab = 1'b0; read_reg_1 = 5'd1; read_reg_2 = 5'd1;
    for (int n = 1; n < 65535; n++) begin
      write_data = n;
      @(negedge clk);
    end
    chk("cnt_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
    write_data = 32'h0001_0000;
    @(negedge clk);
    reg_write = 1'b0;
    dbg_reg = 5'd1;
    #1;
    chk("cnt_wrap", {16'h0, wr_count}, 32'h0);
    chk("hold_a", read_data_a, SpInit);
    chk("hold_b", read_data_b, 32'h0);
    chk("r1_last", dbg_data, 32'h0001_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
